rotshift_serial: RTL and testbench

Bit-serial rotate/shift unit for the SHA-256 datapath. It generalises the fixed-amount serial rotator with four additions: a runtime amount, a logical-shift mode, internal bit counting with word framing, and double buffering, so that a continuous MSB-first word stream is transformed without gaps. It sits between the serial message-schedule/register stream and the σ/Σ XOR networks, sharing the `bclk` strobe with neighbouring serial blocks.

---
 rtl/rotshift_serial.sv | 123 ++++++++++++
 tb/tb_rotshift_serial.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotshift_serial.sv
// Bit-serial rotate/shift unit: double-buffered MSB-first word stream with runtime amount.
// Define ROTSHIFT_SHL_EN to add the logical-left-shift mode (mode=2).
module rotshift_serial #(
  parameter int W  = 32,
  parameter int AW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bclk,
  input  logic          start,
  input  logic          in,
  input  logic [AW-1:0] amt,
  input  logic [1:0]    mode,
  output logic          out,
  output logic          out_valid,
  output logic          word_done
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST  = CW'(W - 1);
  localparam logic [AW:0]   W_EXT = (AW + 1)'(W);

  typedef enum logic {IDLE, RECV} state_t;

  state_t        state;
  logic          bclk_prev;
  logic [W-1:0]  rbuf;
  logic [W-1:0]  pbuf;
  logic [CW-1:0] rcnt;
  logic [CW-1:0] pcnt;
  logic          play_active;
  logic [AW-1:0] pend_amt;
  logic [1:0]    pend_mode;
  logic [AW-1:0] act_amt;
  logic [1:0]    act_mode;

  logic          rec_edge;
  logic          play_edge;
  logic [AW-1:0] r_mod;
  logic [W-1:0]  y;

  assign rec_edge  = bclk & ~bclk_prev;
  assign play_edge = ~bclk & bclk_prev;

  // Amounts can only exceed W-1 for non-power-of-two W, and never reach 2W, so one subtract is a full modulo.
  always_comb begin
    r_mod = act_amt;
    if ({1'b0, act_amt} >= W_EXT)
      r_mod = AW'({1'b0, act_amt} - W_EXT);
    y = W'({pbuf, pbuf} >> r_mod);
`ifdef ROTSHIFT_SHL_EN
    case (act_mode)
      2'd1:    y = pbuf >> act_amt;
      2'd2:    y = pbuf << act_amt;
      default: ;
    endcase
`else
    if (act_mode == 2'd1)
      y = pbuf >> act_amt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bclk_prev   <= 1'b0;
      rbuf        <= '0;
      pbuf        <= '0;
      rcnt        <= '0;
      pcnt        <= '0;
      play_active <= 1'b0;
      pend_amt    <= '0;
      pend_mode   <= '0;
      act_amt     <= '0;
      act_mode    <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      word_done   <= 1'b0;
    end else begin
      bclk_prev <= bclk;
      word_done <= 1'b0;

      // A wrapped counter in RECV frames the next word exactly like an explicit start.
      if (rec_edge) begin
        if (start || (state == RECV && rcnt == '0)) begin
          rbuf      <= {{(W-1){1'b0}}, in};
          pend_amt  <= amt;
          pend_mode <= mode;
          rcnt      <= CW'(1);
          state     <= RECV;
        end else if (state == RECV) begin
          rbuf <= {rbuf[W-2:0], in};
          if (rcnt == LAST) begin
            pbuf        <= {rbuf[W-2:0], in};
            act_amt     <= pend_amt;
            act_mode    <= pend_mode;
            pcnt        <= '0;
            play_active <= 1'b1;
            rcnt        <= '0;
          end else begin
            rcnt <= rcnt + CW'(1);
          end
        end
      end

      if (play_edge) begin
        if (play_active) begin
          out       <= y[LAST - pcnt];
          out_valid <= 1'b1;
          pcnt      <= pcnt + CW'(1);
          if (pcnt == LAST) begin
            word_done   <= 1'b1;
            play_active <= 1'b0;
          end
        end else begin
          out       <= 1'b0;
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rotshift_serial.sv
// Directed bench for rotshift_serial: W=32, bclk period of 8 clk cycles, one bit slot per bclk period.
module tb_rotshift_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bclk = 1'b0;
  logic       start = 1'b0;
  logic       in = 1'b0;
  logic [4:0] amt = '0;
  logic [1:0] mode = '0;
  logic       out;
  logic       out_valid;
  logic       word_done;

  int   checks = 0;
  int   failures = 0;
  int   wd_count = 0;
  logic done_out = 1'b0;
  logic out_hist[$];
  logic val_hist[$];

  rotshift_serial #(.W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bclk      (bclk),
    .start     (start),
    .in        (in),
    .amt       (amt),
    .mode      (mode),
    .out       (out),
    .out_valid (out_valid),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_done === 1'b1) begin
      wd_count = wd_count + 1;
      done_out = out;
    end
  end

  // One bclk period: record half then play half; outputs are logged at the end of the play half.
  task automatic applyStimulus(input logic b, input logic s);
    in    = b;
    start = s;
    bclk  = 1'b1;
    repeat (4) @(negedge clk);
    bclk = 1'b0;
    repeat (4) @(negedge clk);
    out_hist.push_back(out);
    val_hist.push_back(out_valid);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bclk  = 1'b0;
    start = 1'b0;
    in    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_hist.delete();
    val_hist.delete();
  endtask

  function automatic logic [31:0] hist_word(input int base);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      r[31-i] = out_hist[base+i];
    return r;
  endfunction

  function automatic int hist_valid(input int base, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++)
      if (val_hist[base+i] === 1'b1) c++;
    return c;
  endfunction

  task automatic send_word(input logic [31:0] word, input logic [4:0] a, input logic [1:0] m,
                           output logic [31:0] res, output int vcount, output logic early);
    for (int i = 0; i < 63; i++) begin
      if (i == 0) begin
        amt  = a;
        mode = m;
      end
      applyStimulus((i < 32) ? word[31-i] : 1'b0, i == 0);
    end
    res    = hist_word(31);
    vcount = hist_valid(31, 32);
    early  = val_hist[30];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out !== 1'b0) begin failures++; $display("[TB] FAIL reset_out: got %b expected 0", out); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (word_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", word_done); end
    do_reset();
  endtask

  task automatic test_rotr();
    logic [31:0] res;
    int          vc;
    logic        early;
    int          wd0;
    do_reset();
    wd0 = wd_count;
    send_word(32'h80000001, 5'd1, 2'd0, res, vc, early);
    checks++;
    if (res !== 32'hC0000000) begin failures++; $display("[TB] FAIL rotr1: got %h expected c0000000", res); end
    checks++;
    if (vc != 32) begin failures++; $display("[TB] FAIL rotr1_valid: got %0d expected 32", vc); end
    checks++;
    if (early !== 1'b0) begin failures++; $display("[TB] FAIL rotr1_latency: got valid %b before first result expected 0", early); end
    checks++;
    if (wd_count - wd0 != 1) begin failures++; $display("[TB] FAIL rotr1_word_done: got %0d pulses expected 1", wd_count - wd0); end
  endtask

  task automatic test_shr();
    logic [31:0] res;
    int          vc;
    logic        early;
    do_reset();
    send_word(32'hF000000F, 5'd4, 2'd1, res, vc, early);
    checks++;
    if (res !== 32'h0F000000) begin failures++; $display("[TB] FAIL shr4: got %h expected 0f000000", res); end
    do_reset();
    send_word(32'hA5A5A5A5, 5'd0, 2'd1, res, vc, early);
    checks++;
    if (res !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL shr0: got %h expected a5a5a5a5", res); end
    checks++;
    if (done_out !== 1'b1) begin failures++; $display("[TB] FAIL done_align: got out %b at word_done expected 1", done_out); end
    do_reset();
    send_word(32'h80000000, 5'd31, 2'd1, res, vc, early);
    checks++;
    if (res !== 32'h00000001) begin failures++; $display("[TB] FAIL shr31: got %h expected 00000001", res); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa;
    logic [31:0] wb;
    int          wd0;
    do_reset();
    wd0 = wd_count;
    wa = 32'h6A09E667;
    wb = 32'h00000001;
    for (int i = 0; i < 96; i++) begin
      case (i)
        0:  begin amt = 5'd7;  mode = 2'd0; end
        10: begin amt = 5'd5;  mode = 2'd1; end
        32: begin amt = 5'd18; mode = 2'd0; end
        40: begin amt = 5'd3;  mode = 2'd1; end
        default: ;
      endcase
      if (i < 32)      applyStimulus(wa[31-i], i == 0);
      else if (i < 64) applyStimulus(wb[63-i], 1'b0);
      else             applyStimulus(1'b0, 1'b0);
    end
    checks++;
    if (hist_word(31) !== 32'hCED413CC) begin failures++; $display("[TB] FAIL b2b_first: got %h expected ced413cc", hist_word(31)); end
    checks++;
    if (hist_word(63) !== 32'h00004000) begin failures++; $display("[TB] FAIL b2b_second: got %h expected 00004000", hist_word(63)); end
    checks++;
    if (hist_valid(31, 64) != 64) begin failures++; $display("[TB] FAIL b2b_valid: got %0d expected 64", hist_valid(31, 64)); end
    checks++;
    if (wd_count - wd0 != 2) begin failures++; $display("[TB] FAIL b2b_word_done: got %0d expected 2", wd_count - wd0); end
  endtask

  task automatic test_restart();
    logic [31:0] wp;
    logic [31:0] wq;
    int          wd0;
    do_reset();
    wd0 = wd_count;
    wp = 32'h80000001;
    wq = 32'h12345678;
    for (int i = 0; i < 105; i++) begin
      if (i == 0)  begin amt = 5'd1; mode = 2'd0; end
      if (i == 42) begin amt = 5'd8; mode = 2'd1; end
      if (i < 32)       applyStimulus(wp[31-i], i == 0);
      else if (i < 42)  applyStimulus(1'b1, 1'b0);
      else if (i < 74)  applyStimulus(wq[73-i], i == 42);
      else              applyStimulus(1'b0, 1'b0);
    end
    checks++;
    if (hist_word(31) !== 32'hC0000000) begin failures++; $display("[TB] FAIL restart_prev: got %h expected c0000000", hist_word(31)); end
    checks++;
    if (val_hist[63] !== 1'b0) begin failures++; $display("[TB] FAIL restart_gap: got valid %b expected 0", val_hist[63]); end
    checks++;
    if (hist_word(73) !== 32'h00123456) begin failures++; $display("[TB] FAIL restart_new: got %h expected 00123456", hist_word(73)); end
    checks++;
    if (hist_valid(73, 32) != 32) begin failures++; $display("[TB] FAIL restart_valid: got %0d expected 32", hist_valid(73, 32)); end
    checks++;
    if (wd_count - wd0 != 2) begin failures++; $display("[TB] FAIL restart_word_done: got %0d expected 2", wd_count - wd0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    amt  = 5'd0;
    mode = 2'd0;
    for (int i = 0; i < 46; i++)
      applyStimulus(i < 32, i == 0);
    in    = 1'b0;
    start = 1'b0;
    bclk  = 1'b1;
    repeat (4) @(negedge clk);
    bclk = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out !== 1'b1 || out_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL areset_pre: got out=%b valid=%b expected 1/1", out, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0) begin failures++; $display("[TB] FAIL areset_out: got %b expected 0", out); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_valid: got %b expected 0", out_valid); end
    checks++;
    if (word_done !== 1'b0) begin failures++; $display("[TB] FAIL areset_done: got %b expected 0", word_done); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_hist.delete();
    val_hist.delete();
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b1, 1'b0);
    checks++;
    if (hist_valid(0, 40) != 0) begin failures++; $display("[TB] FAIL areset_quiet: got %0d valid bits expected 0", hist_valid(0, 40)); end
  endtask

  task automatic test_shl();
    logic [31:0] res;
    logic [31:0] exp_shl;
    int          vc;
    logic        early;
`ifdef ROTSHIFT_SHL_EN
    exp_shl = 32'h80000008;
`else
    exp_shl = 32'h22000000;
`endif
    do_reset();
    send_word(32'h10000001, 5'd3, 2'd2, res, vc, early);
    checks++;
    if (res !== exp_shl) begin failures++; $display("[TB] FAIL mode2: got %h expected %h", res, exp_shl); end
    do_reset();
    send_word(32'h10000001, 5'd3, 2'd3, res, vc, early);
    checks++;
    if (res !== 32'h22000000) begin failures++; $display("[TB] FAIL mode3: got %h expected 22000000", res); end
  endtask

  initial begin
    test_reset();
    test_rotr();
    test_shr();
    test_back_to_back();
    test_restart();
    test_async_reset();
    test_shl();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
